vga_scanout: RTL

VGA_SCANOUT -- requirements
Module: vga_scanout

---
 rtl/vga_scanout.sv | 122 ++++++++++++
 1 files changed

// File: rtl/vga_scanout.sv
// vga_scanout: VGA timing generator and frame-buffer scan-out.
// Walks a raster of H_TOTAL x V_TOTAL pixel clocks. It issues frame-buffer
// read addresses for the visible area and drives sync and video to the DAC
// through a two-stage pipeline. It also pulses swap once per frame, on the
// first vertical-blanking line.
//
// Ports
//   clk        in   pixel clock; all state changes on its rising edge
//   rst_n      in   synchronous active-low reset
//   read_addr  out  frame-buffer read address (ADDR_WIDTH)
//   read_data  in   frame-buffer pixel, valid one cycle after read_addr
//   swap       out  one-cycle pulse to the frame-buffer swap input
//   hsync      out  horizontal sync, active low
//   vsync      out  vertical sync, active low
//   video      out  pixel to the DAC, 0 outside the active area
module vga_scanout #(
    parameter int unsigned HOR_ACTIVE_PIXELS = 640,
    parameter int unsigned VER_ACTIVE_PIXELS = 480,
    parameter int unsigned HOR_FRONT_PORCH   = 16,
    parameter int unsigned HOR_SYNC          = 96,
    parameter int unsigned HOR_BACK_PORCH    = 48,
    parameter int unsigned VER_FRONT_PORCH   = 10,
    parameter int unsigned VER_SYNC          = 2,
    parameter int unsigned VER_BACK_PORCH    = 33,
    localparam int unsigned ADDR_WIDTH       = $clog2(HOR_ACTIVE_PIXELS * VER_ACTIVE_PIXELS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [ADDR_WIDTH-1:0] read_addr,
    input  logic                  read_data,
    output logic                  swap,
    output logic                  hsync,
    output logic                  vsync,
    output logic                  video
);

    localparam int unsigned H_TOTAL = HOR_ACTIVE_PIXELS + HOR_FRONT_PORCH + HOR_SYNC + HOR_BACK_PORCH;
    localparam int unsigned V_TOTAL = VER_ACTIVE_PIXELS + VER_FRONT_PORCH + VER_SYNC + VER_BACK_PORCH;
    localparam int unsigned HW      = $clog2(H_TOTAL);
    localparam int unsigned VW      = $clog2(V_TOTAL);

    localparam int unsigned H_SYNC_START = HOR_ACTIVE_PIXELS + HOR_FRONT_PORCH;
    localparam int unsigned H_SYNC_END   = H_SYNC_START + HOR_SYNC;
    localparam int unsigned V_SYNC_START = VER_ACTIVE_PIXELS + VER_FRONT_PORCH;
    localparam int unsigned V_SYNC_END   = V_SYNC_START + VER_SYNC;

    logic [HW-1:0] r_h;
    logic [VW-1:0] r_v;

    // Stage-1 copies of the per-position flags, aligned with read_data.
    logic          r_de_d1;
    logic          r_hs_d1;
    logic          r_vs_d1;

    logic          w_h_last;
    logic          w_v_last;
    logic          w_de;
    logic          w_hs_n;
    logic          w_vs_n;
    logic          w_last_px;
    logic          w_swap_next;

    // Position decode for the current (h, v).
    always_comb begin
        w_h_last    = 1'b0;
        w_v_last    = 1'b0;
        w_de        = 1'b0;
        w_hs_n      = 1'b1;
        w_vs_n      = 1'b1;
        w_last_px   = 1'b0;
        w_swap_next = 1'b0;

        w_h_last  = (r_h == HW'(H_TOTAL - 1));
        w_v_last  = (r_v == VW'(V_TOTAL - 1));
        w_de      = (r_h < HW'(HOR_ACTIVE_PIXELS)) && (r_v < VW'(VER_ACTIVE_PIXELS));
        w_hs_n    = !((r_h >= HW'(H_SYNC_START)) && (r_h < HW'(H_SYNC_END)));
        w_vs_n    = !((r_v >= VW'(V_SYNC_START)) && (r_v < VW'(V_SYNC_END)));
        w_last_px = (r_h == HW'(HOR_ACTIVE_PIXELS - 1)) && (r_v == VW'(VER_ACTIVE_PIXELS - 1));
        // Next position is (0, VER_ACTIVE_PIXELS): register swap so it is high there.
        w_swap_next = w_h_last && (r_v == VW'(VER_ACTIVE_PIXELS - 1));
    end

    // Raster counters, address counter and output pipeline.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_h       <= '0;
            r_v       <= '0;
            read_addr <= '0;
            swap      <= 1'b0;
            r_de_d1   <= 1'b0;
            r_hs_d1   <= 1'b1;
            r_vs_d1   <= 1'b1;
            video     <= 1'b0;
            hsync     <= 1'b1;
            vsync     <= 1'b1;
        end else begin
            r_h <= w_h_last ? '0 : r_h + HW'(1);
            if (w_h_last) begin
                r_v <= w_v_last ? '0 : r_v + VW'(1);
            end

            // Incrementing past the end of a line lands on the next line's
            // first address, so the value simply holds through h-blanking.
            if (w_last_px) begin
                read_addr <= '0;
            end else if (w_de) begin
                read_addr <= read_addr + ADDR_WIDTH'(1);
            end

            swap <= w_swap_next;

            r_de_d1 <= w_de;
            r_hs_d1 <= w_hs_n;
            r_vs_d1 <= w_vs_n;

            video <= r_de_d1 & read_data;
            hsync <= r_hs_d1;
            vsync <= r_vs_d1;
        end
    end

endmodule
